// File: rtl/dmem_axi_pkg.sv
// rtl/dmem_axi_pkg.sv - shared state encoding and AXI response codes for dmem_axil_port
package dmem_axi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RD_RESP = 3'd5
  } dmem_axi_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/dmem_axil_port.sv
// rtl/dmem_axil_port.sv - AXI4-Lite responder driving data-memory port B, one transaction at a time
// Optional: DMEM_AXI_RANGE_CHECK_EN flags out-of-range addresses with SLVERR and suppresses the access.
module dmem_axil_port
  import dmem_axi_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SIZE       = 256,
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [WIDTH-1:0]      s_axi_wdata,
  input  logic [NUM_COL-1:0]    s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [WIDTH-1:0]      s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [WIDTH-1:0]      AXI_dmem_data_in,
  input  logic [WIDTH-1:0]      AXI_dmem_data_out,
  output logic [$clog2(SIZE)+1:0] AXI_dmem_word_addr,
  output logic [NUM_COL-1:0]    AXI_dmem_byte_wr_en
);

  localparam int LOGSIZE = $clog2(SIZE);

  dmem_axi_state_t      state_q, state_d;
  logic                 rr_last_wr_q, rr_last_wr_d;
  logic                 ready_q, ready_d;
  logic [LOGSIZE-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]     wdata_q, wdata_d;
  logic [NUM_COL-1:0]   wstrb_q, wstrb_d;
  logic                 err_q, err_d;
  logic [1:0]           bresp_q, bresp_d;
  logic [1:0]           rresp_q, rresp_d;
  logic [WIDTH-1:0]     rdata_q, rdata_d;

  logic wr_req, rd_req, grant_wr, grant_rd;
  logic aw_err, ar_err;

`ifdef DMEM_AXI_RANGE_CHECK_EN
  assign aw_err = |s_axi_awaddr[ADDR_WIDTH-1:LOGSIZE+2];
  assign ar_err = |s_axi_araddr[ADDR_WIDTH-1:LOGSIZE+2];
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[ADDR_WIDTH-1:LOGSIZE+2], s_axi_awaddr[1:0],
                              s_axi_araddr[ADDR_WIDTH-1:LOGSIZE+2], s_axi_araddr[1:0]};
`endif

  // A write needs AW and W together; on a tie the channel not served last time wins.
  assign wr_req   = s_axi_awvalid & s_axi_wvalid;
  assign rd_req   = s_axi_arvalid;
  assign grant_wr = ready_q & wr_req & (~rd_req | ~rr_last_wr_q);
  assign grant_rd = ready_q & rd_req & ~grant_wr;

  always_comb begin
    state_d      = state_q;
    rr_last_wr_d = rr_last_wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    err_d        = err_q;
    bresp_d      = bresp_q;
    rresp_d      = rresp_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          state_d      = WR;
          rr_last_wr_d = 1'b1;
          addr_d       = s_axi_awaddr[LOGSIZE+1:2];
          wdata_d      = s_axi_wdata;
          wstrb_d      = s_axi_wstrb;
          err_d        = aw_err;
          bresp_d      = aw_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        end else if (grant_rd) begin
          state_d      = RD_ADDR;
          rr_last_wr_d = 1'b0;
          addr_d       = s_axi_araddr[LOGSIZE+1:2];
          err_d        = ar_err;
          rresp_d      = ar_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        end
      end
      WR:      state_d = WR_RESP;
      WR_RESP: if (s_axi_bready) state_d = IDLE;
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        rdata_d = err_q ? '0 : AXI_dmem_data_out;
        state_d = RD_RESP;
      end
      RD_RESP: if (s_axi_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Registered so that every output, readies included, is low while in reset.
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rr_last_wr_q <= 1'b0;
      ready_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      err_q        <= 1'b0;
      bresp_q      <= AXI_RESP_OKAY;
      rresp_q      <= AXI_RESP_OKAY;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      rr_last_wr_q <= rr_last_wr_d;
      ready_q      <= ready_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      err_q        <= err_d;
      bresp_q      <= bresp_d;
      rresp_q      <= rresp_d;
      rdata_q      <= rdata_d;
    end
  end

  assign s_axi_awready = ready_q & ~grant_rd;
  assign s_axi_wready  = ready_q & ~grant_rd;
  assign s_axi_arready = ready_q & ~grant_wr;
  assign s_axi_bvalid  = (state_q == WR_RESP);
  assign s_axi_rvalid  = (state_q == RD_RESP);
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;

  // Strobes are gated by the state so an asynchronous reset kills a write in flight.
  assign AXI_dmem_byte_wr_en = (state_q == WR && !err_q) ? wstrb_q : '0;
  assign AXI_dmem_data_in    = wdata_q;
  assign AXI_dmem_word_addr  = {2'b00, addr_q};

endmodule

// File: tb/tb_dmem_axil_port.sv
// tb/tb_dmem_axil_port.sv - randomized self-checking bench for dmem_axil_port with a word-level memory model
module tb_dmem_axil_port;

`ifdef DMEM_AXI_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [3:0]  s_axi_wstrb;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready;
  logic [31:0] AXI_dmem_data_in, AXI_dmem_data_out;
  logic [9:0]  AXI_dmem_word_addr;
  logic [3:0]  AXI_dmem_byte_wr_en;

  dmem_axil_port dut (
    .clk(clk), .reset(reset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .AXI_dmem_data_in(AXI_dmem_data_in), .AXI_dmem_data_out(AXI_dmem_data_out),
    .AXI_dmem_word_addr(AXI_dmem_word_addr), .AXI_dmem_byte_wr_en(AXI_dmem_byte_wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          init_done = 1'b0;
  bit          rr_last  = 1'b0;
  logic [31:0] ref_mem [256];
  logic [31:0] hmem    [256];
  logic [31:0] last_rdata;

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {b, ~b, b ^ 8'h5A, 8'hC3};
  endfunction

  function automatic bit range_err(input logic [31:0] ad);
    return RC & (|ad[31:10]);
  endfunction

  // Port-B memory stand-in: byte-enabled write, registered read.
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) hmem[i] <= init_word(i);
    end else begin
      for (int c = 0; c < 4; c++)
        if (AXI_dmem_byte_wr_en[c]) hmem[AXI_dmem_word_addr[7:0]][c*8 +: 8] <= AXI_dmem_data_in[c*8 +: 8];
    end
    AXI_dmem_data_out <= hmem[AXI_dmem_word_addr[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_grant(output bit got_wr, output bit got_rd);
    got_wr = 1'b0;
    got_rd = 1'b0;
    for (int i = 0; i < 20 && !got_wr && !got_rd; i++) begin
      #1;
      if (s_axi_awvalid && s_axi_wvalid && s_axi_awready && s_axi_wready) got_wr = 1'b1;
      else if (s_axi_arvalid && s_axi_arready) got_rd = 1'b1;
      @(negedge clk);
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    s_axi_arvalid = 1'b0;
    if (!got_wr && !got_rd) check("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_txn(input bit want_wr, input bit want_rd, input logic [31:0] waddr,
                         input logic [31:0] wdat, input logic [3:0] strb,
                         input logic [31:0] raddr, input int hold);
    bit got_wr, got_rd, exp_wr, err;
    int n;
    logic [7:0]  a;
    logic [31:0] exp_d;
    s_axi_awaddr  = waddr;
    s_axi_wdata   = wdat;
    s_axi_wstrb   = strb;
    s_axi_araddr  = raddr;
    s_axi_awvalid = want_wr;
    s_axi_wvalid  = want_wr;
    s_axi_arvalid = want_rd;
    wait_grant(got_wr, got_rd);
    if (!got_wr && !got_rd) return;
    exp_wr = want_wr && (!want_rd || !rr_last);
    check("grant_is_wr", {31'd0, got_wr}, {31'd0, exp_wr});
    rr_last = got_wr;
    if (got_wr) begin
      a   = waddr[9:2];
      err = range_err(waddr);
      check("wr_en", {28'd0, AXI_dmem_byte_wr_en}, err ? 32'd0 : {28'd0, strb});
      check("wr_word_addr", {22'd0, AXI_dmem_word_addr}, {24'd0, a});
      check("wr_data", AXI_dmem_data_in, wdat);
      if (!err)
        for (int c = 0; c < 4; c++) if (strb[c]) ref_mem[a][c*8 +: 8] = wdat[c*8 +: 8];
      n = 0;
      while (!s_axi_bvalid && n < 8) begin @(negedge clk); n++; end
      check("b_latency", n, 1);
      check("bresp", {30'd0, s_axi_bresp}, err ? 32'd2 : 32'd0);
      for (int i = 0; i < hold; i++) begin
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
        @(negedge clk);
        check("b_hold", {28'd0, s_axi_awready, s_axi_arready, s_axi_bvalid, AXI_dmem_byte_wr_en != 4'd0},
              32'd2);
        check("b_hold_resp", {30'd0, s_axi_bresp}, err ? 32'd2 : 32'd0);
      end
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      s_axi_bready = 1'b1;
      @(negedge clk);
      s_axi_bready = 1'b0;
      check("b_done", {31'd0, s_axi_bvalid}, 32'd0);
    end else begin
      a     = raddr[9:2];
      err   = range_err(raddr);
      exp_d = err ? 32'd0 : ref_mem[a];
      check("rd_word_addr", {22'd0, AXI_dmem_word_addr}, {24'd0, a});
      n = 0;
      while (!s_axi_rvalid && n < 8) begin @(negedge clk); n++; end
      check("r_latency", n, 2);
      check("rdata", s_axi_rdata, exp_d);
      check("rresp", {30'd0, s_axi_rresp}, err ? 32'd2 : 32'd0);
      for (int i = 0; i < hold; i++) begin
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
        @(negedge clk);
        check("r_hold", {29'd0, s_axi_awready, s_axi_arready, s_axi_rvalid}, 32'd1);
        check("r_hold_data", s_axi_rdata, exp_d);
      end
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      s_axi_rready = 1'b1;
      @(negedge clk);
      s_axi_rready = 1'b0;
      check("r_done", {31'd0, s_axi_rvalid}, 32'd0);
      check("r_keep", s_axi_rdata, exp_d);
      last_rdata = s_axi_rdata;
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {17'd0, s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
            s_axi_bresp, s_axi_rresp, |s_axi_rdata, |AXI_dmem_data_in, |AXI_dmem_word_addr,
            AXI_dmem_byte_wr_en};
  endfunction

  initial begin
    bit gw, gr, seen;
    logic [31:0] ad;
    reset = 1'b0;
    s_axi_awaddr = '0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_araddr = '0;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    repeat (3) @(negedge clk);
    init_done = 1'b1;
    check("reset_outputs", all_outs(), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Ties straight out of reset: write first, then read.
    run_txn(1, 1, 32'h0000_0040, 32'hCAFE_0001, 4'hF, 32'h0000_0044, 0);
    run_txn(1, 1, 32'h0000_0048, 32'hCAFE_0002, 4'hF, 32'h0000_0040, 0);

    s_axi_awaddr = 32'h50; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); seen |= s_axi_bvalid | (AXI_dmem_byte_wr_en != 4'd0); end
    check("aw_only_no_grant", {31'd0, seen}, 32'd0);
    s_axi_awvalid = 1'b0;
    @(negedge clk);

    run_txn(1, 0, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 0);
    run_txn(0, 1, 32'h0, 32'h0, 4'h0, 32'h10, 0);
    check("t1_rdata", last_rdata, 32'hDEAD_BEEF);

    run_txn(1, 0, 32'h10, 32'h1122_3344, 4'hF, 32'h0, 0);
    run_txn(1, 0, 32'h10, 32'h0000_00AA, 4'h1, 32'h0, 0);
    run_txn(0, 1, 32'h0, 32'h0, 4'h0, 32'h10, 0);
    check("strb_merge", last_rdata, 32'h1122_33AA);
    run_txn(1, 0, 32'h10, 32'hFFFF_FFFF, 4'h0, 32'h0, 0);
    run_txn(0, 1, 32'h0, 32'h0, 4'h0, 32'h10, 0);
    check("strb_zero", last_rdata, 32'h1122_33AA);

    run_txn(1, 0, 32'h84, 32'h0BAD_F00D, 4'hA, 32'h0, 5);
    run_txn(0, 1, 32'h0, 32'h0, 4'h0, 32'h84, 5);

    run_txn(1, 0, 32'h0, 32'h0000_1234, 4'hF, 32'h0, 0);
    run_txn(1, 0, 32'h400, 32'h0000_0055, 4'hF, 32'h0, 0);
    run_txn(0, 1, 32'h0, 32'h0, 4'h0, 32'h400, 0);
    check("range_rd_400", last_rdata, RC ? 32'h0 : 32'h0000_0055);
    run_txn(0, 1, 32'h0, 32'h0, 4'h0, 32'h0, 0);
    check("range_rd_0", last_rdata, RC ? 32'h0000_1234 : 32'h0000_0055);

    // Reset in RD_DATA.
    s_axi_araddr = 32'h20; s_axi_arvalid = 1'b1;
    wait_grant(gw, gr);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_read", all_outs(), 32'd0);
    rr_last = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); seen |= s_axi_rvalid | s_axi_bvalid; end
    check("no_resp_after_reset", {31'd0, seen}, 32'd0);
    run_txn(0, 1, 32'h0, 32'h0, 4'h0, 32'h20, 0);

    // Reset while the write strobe is on the bus.
    s_axi_awaddr = 32'h30; s_axi_wdata = 32'h7777_7777; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    wait_grant(gw, gr);
    check("wr_en_before_reset", {28'd0, AXI_dmem_byte_wr_en}, 32'hF);
    reset = 1'b0;
    #1;
    check("wr_en_async_drop", {28'd0, AXI_dmem_byte_wr_en}, 32'd0);
    rr_last = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_txn(0, 1, 32'h0, 32'h0, 4'h0, 32'h30, 0);

    for (int it = 0; it < 40; it++) begin
      int kind;
      logic [31:0] wa, ra;
      kind = $urandom_range(0, 2);
      wa = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
      ra = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) wa[10 + $urandom_range(0, 21)] = 1'b1;
      if ($urandom_range(0, 7) == 0) ra[10 + $urandom_range(0, 21)] = 1'b1;
      if (kind == 1 && $urandom_range(0, 1) == 1) ra = wa;
      ad = $urandom;
      run_txn(kind != 1, kind != 0, wa, ad, 4'($urandom_range(0, 15)), ra, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
